// File: rtl/ikbd_host_uart.sv
// 8N1 host-side UART for the IKBD link: oversampling receiver feeding a small
// RX FIFO, plus an independent transmitter. Both FSMs are visible on debug ports.
//
// Handshakes: a byte moves on any rising clk edge where valid and ready are both
// high. The RX side holds rx_data/rx_valid stable until popped. The TX side
// latches tx_data on accept and ignores tx_valid until tx_ready returns.
module ikbd_host_uart #(
   parameter int DIV        = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic       clk,
   input  logic       res,
   input  logic       rxd,
   output logic       txd,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       rx_ferr,
   output logic       rx_ovr,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic [1:0] rx_state_dbg,
   output logic [1:0] tx_state_dbg
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam int TW = $clog2(16 * DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
   localparam logic [TW-1:0] TX_MAX  = TW'(16 * DIV - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // ---------------------------------------------------------------- synchronizer
   logic rxd_meta, rxd_sync;

   always_ff @(posedge clk) begin
      if (res) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= rxd;
         rxd_sync <= rxd_meta;
      end
   end

   // ---------------------------------------------------------------- receiver
   state_t          rx_st, rx_st_n;
   logic [PW-1:0]   rx_pre, rx_pre_n;
   logic [3:0]      rx_sub, rx_sub_n;
   logic [2:0]      rx_bit, rx_bit_n;
   logic [7:0]      rx_shreg, rx_shreg_n;
   logic            rx_armed, rx_armed_n;
   logic            rx_tick;
   logic            rx_push;
   logic            rx_ferr_n;

   always_comb begin
      rx_st_n    = rx_st;
      rx_pre_n   = rx_pre;
      rx_sub_n   = rx_sub;
      rx_bit_n   = rx_bit;
      rx_shreg_n = rx_shreg;
      rx_push    = 1'b0;
      rx_ferr_n  = 1'b0;
      rx_tick    = (rx_pre == PRE_MAX);
      // A start is only honoured once the line has been seen high since the
      // last framing error or reset.
      rx_armed_n = rxd_sync ? 1'b1 : rx_armed;

      if (rx_st != S_IDLE)
         rx_pre_n = rx_tick ? '0 : rx_pre + PW'(1);

      case (rx_st)
         S_IDLE: begin
            rx_pre_n = '0;
            if (!rxd_sync && rx_armed) begin
               rx_st_n  = S_START;
               rx_sub_n = 4'd0;
            end
         end
         S_START: begin
            if (rx_tick) begin
               if (rx_sub == 4'd7) begin
                  rx_sub_n = 4'd0;
                  rx_bit_n = 3'd0;
                  rx_st_n  = rxd_sync ? S_IDLE : S_DATA;
               end else begin
                  rx_sub_n = rx_sub + 4'd1;
               end
            end
         end
         S_DATA: begin
            if (rx_tick) begin
               if (rx_sub == 4'd15) begin
                  rx_sub_n   = 4'd0;
                  rx_shreg_n = {rxd_sync, rx_shreg[7:1]};
                  rx_bit_n   = rx_bit + 3'd1;
                  if (rx_bit == 3'd7)
                     rx_st_n = S_STOP;
               end else begin
                  rx_sub_n = rx_sub + 4'd1;
               end
            end
         end
         S_STOP: begin
            if (rx_tick) begin
               if (rx_sub == 4'd15) begin
                  rx_sub_n = 4'd0;
                  rx_st_n  = S_IDLE;
                  if (rxd_sync) begin
                     rx_push = 1'b1;
                  end else begin
                     rx_ferr_n  = 1'b1;
                     rx_armed_n = 1'b0;
                  end
               end else begin
                  rx_sub_n = rx_sub + 4'd1;
               end
            end
         end
         default: rx_st_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         rx_st    <= S_IDLE;
         rx_pre   <= '0;
         rx_sub   <= 4'd0;
         rx_bit   <= 3'd0;
         rx_shreg <= 8'd0;
         rx_armed <= 1'b0;
      end else begin
         rx_st    <= rx_st_n;
         rx_pre   <= rx_pre_n;
         rx_sub   <= rx_sub_n;
         rx_bit   <= rx_bit_n;
         rx_shreg <= rx_shreg_n;
         rx_armed <= rx_armed_n;
      end
   end

   // ---------------------------------------------------------------- rx fifo
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          pop, full, do_push, ovr_n;

   assign pop     = rx_valid && rx_ready;
   assign full    = (count == FULL_CNT);
   // A pop in the same cycle frees the slot the push needs.
   assign do_push = rx_push && (!full || pop);
   assign ovr_n   = rx_push && full && !pop;

   always_ff @(posedge clk) begin
      if (do_push)
         mem[wr_ptr] <= rx_shreg;
   end

   always_ff @(posedge clk) begin
      if (res) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rx_ferr <= 1'b0;
         rx_ovr  <= 1'b0;
      end else begin
         rx_ferr <= rx_ferr_n;
         rx_ovr  <= ovr_n;
         if (do_push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign rx_valid     = (count != '0);
   assign rx_data      = mem[rd_ptr];
   assign rx_state_dbg = rx_st;

   // ---------------------------------------------------------------- transmitter
   state_t        tx_st, tx_st_n;
   logic [TW-1:0] tx_cnt, tx_cnt_n;
   logic [2:0]    tx_bit, tx_bit_n;
   logic [7:0]    tx_shreg, tx_shreg_n;
   logic          txd_n;
   logic          tx_bit_end;

   assign tx_ready = (tx_st == S_IDLE);

   always_comb begin
      tx_st_n    = tx_st;
      tx_cnt_n   = tx_cnt;
      tx_bit_n   = tx_bit;
      tx_shreg_n = tx_shreg;
      tx_bit_end = (tx_cnt == TX_MAX);

      if (tx_st != S_IDLE)
         tx_cnt_n = tx_bit_end ? '0 : tx_cnt + TW'(1);

      case (tx_st)
         S_IDLE: begin
            tx_cnt_n = '0;
            if (tx_valid) begin
               tx_shreg_n = tx_data;
               tx_st_n    = S_START;
            end
         end
         S_START: begin
            if (tx_bit_end) begin
               tx_bit_n = 3'd0;
               tx_st_n  = S_DATA;
            end
         end
         S_DATA: begin
            if (tx_bit_end) begin
               if (tx_bit == 3'd7) begin
                  tx_st_n = S_STOP;
               end else begin
                  tx_shreg_n = {1'b0, tx_shreg[7:1]};
                  tx_bit_n   = tx_bit + 3'd1;
               end
            end
         end
         S_STOP: begin
            if (tx_bit_end)
               tx_st_n = S_IDLE;
         end
         default: tx_st_n = S_IDLE;
      endcase

      // The line level is registered from the next state so txd never glitches.
      case (tx_st_n)
         S_START: txd_n = 1'b0;
         S_DATA:  txd_n = tx_shreg_n[0];
         default: txd_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (res) begin
         tx_st    <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= 3'd0;
         tx_shreg <= 8'd0;
         txd      <= 1'b1;
      end else begin
         tx_st    <= tx_st_n;
         tx_cnt   <= tx_cnt_n;
         tx_bit   <= tx_bit_n;
         tx_shreg <= tx_shreg_n;
         txd      <= txd_n;
      end
   end

   assign tx_state_dbg = tx_st;

endmodule

// File: tb/tb_ikbd_host_uart.sv
// Bench for ikbd_host_uart: instance a (DIV=1) covers RX, FIFO and reset;
// instance b (DIV=2) covers TX waveform timing.
module tb_ikbd_host_uart;

   localparam int BIT_A = 16;
   localparam int BIT_B = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       res;
   logic       rxd_a, txd_a, rx_valid_a, rx_ready_a, rx_ferr_a, rx_ovr_a, tx_valid_a, tx_ready_a;
   logic [7:0] rx_data_a, tx_data_a;
   logic [1:0] rxs_a, txs_a;
   logic       rxd_b, txd_b, rx_valid_b, rx_ready_b, rx_ferr_b, rx_ovr_b, tx_valid_b, tx_ready_b;
   logic [7:0] rx_data_b, tx_data_b;
   logic [1:0] rxs_b, txs_b;

   ikbd_host_uart #(.DIV(1), .FIFO_DEPTH(DEPTH)) u_dut_a (
      .clk(clk), .res(res), .rxd(rxd_a), .txd(txd_a),
      .rx_data(rx_data_a), .rx_valid(rx_valid_a), .rx_ready(rx_ready_a),
      .rx_ferr(rx_ferr_a), .rx_ovr(rx_ovr_a),
      .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready_a),
      .rx_state_dbg(rxs_a), .tx_state_dbg(txs_a)
   );

   ikbd_host_uart #(.DIV(2), .FIFO_DEPTH(DEPTH)) u_dut_b (
      .clk(clk), .res(res), .rxd(rxd_b), .txd(txd_b),
      .rx_data(rx_data_b), .rx_valid(rx_valid_b), .rx_ready(rx_ready_b),
      .rx_ferr(rx_ferr_b), .rx_ovr(rx_ovr_b),
      .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready_b),
      .rx_state_dbg(rxs_b), .tx_state_dbg(txs_b)
   );

   int vec_cnt = 0;
   int err_cnt = 0;
   int ferr_cnt = 0, ovr_cnt = 0, ferr_long = 0, ovr_long = 0;
   logic ferr_prev = 1'b0, ovr_prev = 1'b0;
   logic [7:0] exp_q[$];

   // Pulse monitor for instance a: counts flag pulses and pulses wider than one cycle.
   always @(negedge clk) begin
      if (rx_ferr_a) ferr_cnt++;
      if (rx_ovr_a) ovr_cnt++;
      if (rx_ferr_a && ferr_prev) ferr_long++;
      if (rx_ovr_a && ovr_prev) ovr_long++;
      ferr_prev = rx_ferr_a;
      ovr_prev  = rx_ovr_a;
   end

   // ---------------------------------------------------------------- drivers
   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      logic [9:0] fr;
      fr = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rxd_a = fr[i];
         repeat (BIT_A) @(negedge clk);
      end
      rxd_a = 1'b1;
      repeat (BIT_A) @(negedge clk);
   endtask

   task automatic pop_one();
      rx_ready_a = 1'b1;
      @(negedge clk);
      rx_ready_a = 1'b0;
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      res = 1'b1;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if ({txd_a, tx_ready_a, rx_valid_a, rx_ferr_a, rx_ovr_a, rxs_a, txs_a} !== 9'b110000000) begin
         err_cnt++;
         $display("FAIL reset_a got %b exp 110000000",
                  {txd_a, tx_ready_a, rx_valid_a, rx_ferr_a, rx_ovr_a, rxs_a, txs_a});
      end
      vec_cnt++;
      if ({txd_b, tx_ready_b, rx_valid_b, rx_ferr_b, rx_ovr_b, rxs_b, txs_b} !== 9'b110000000) begin
         err_cnt++;
         $display("FAIL reset_b got %b exp 110000000",
                  {txd_b, tx_ready_b, rx_valid_b, rx_ferr_b, rx_ovr_b, rxs_b, txs_b});
      end
      res = 1'b0;
      repeat (5) @(negedge clk);
      vec_cnt++;
      if ({txd_a, tx_ready_a, rx_valid_a, rxs_a} !== 5'b11000) begin
         err_cnt++;
         $display("FAIL idle_after_reset got %b exp 11000", {txd_a, tx_ready_a, rx_valid_a, rxs_a});
      end
   endtask

   task automatic test_rx_basic();
      send_rx(8'hF1, 1'b1);
      vec_cnt++;
      if (rx_valid_a !== 1'b1 || rx_data_a !== 8'hF1) begin
         err_cnt++;
         $display("FAIL rx_basic got valid=%b data=%h exp valid=1 data=f1", rx_valid_a, rx_data_a);
      end
      pop_one();
      vec_cnt++;
      if (rx_valid_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL rx_basic_pop got valid=%b exp 0", rx_valid_a);
      end
      vec_cnt++;
      if (ferr_cnt !== 0 || ovr_cnt !== 0) begin
         err_cnt++;
         $display("FAIL rx_basic_flags got ferr=%0d ovr=%0d exp 0 0", ferr_cnt, ovr_cnt);
      end
   endtask

   task automatic test_glitch();
      int f0;
      f0 = ferr_cnt;
      rxd_a = 1'b0;
      repeat (5) @(negedge clk);
      rxd_a = 1'b1;
      repeat (40) @(negedge clk);
      vec_cnt++;
      if (rx_valid_a !== 1'b0 || ferr_cnt !== f0 || rxs_a !== 2'd0) begin
         err_cnt++;
         $display("FAIL glitch got valid=%b ferr=%0d state=%0d exp 0 %0d 0", rx_valid_a, ferr_cnt, rxs_a, f0);
      end
      send_rx(8'h55, 1'b1);
      vec_cnt++;
      if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h55) begin
         err_cnt++;
         $display("FAIL glitch_next got valid=%b data=%h exp 1 55", rx_valid_a, rx_data_a);
      end
      pop_one();
   endtask

   task automatic test_ferr();
      int f0;
      logic [7:0] b;
      f0 = ferr_cnt;
      send_rx(8'hAA, 1'b0);
      vec_cnt++;
      if (ferr_cnt !== f0 + 1 || ferr_long !== 0) begin
         err_cnt++;
         $display("FAIL ferr_pulse got %0d pulses (%0d wide) exp %0d (0 wide)", ferr_cnt - f0, ferr_long, 1);
      end
      vec_cnt++;
      if (rx_valid_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL ferr_nopush got valid=%b exp 0", rx_valid_a);
      end
      b = 8'($urandom);
      send_rx(b, 1'b1);
      vec_cnt++;
      if (rx_valid_a !== 1'b1 || rx_data_a !== b) begin
         err_cnt++;
         $display("FAIL ferr_recover got valid=%b data=%h exp 1 %h", rx_valid_a, rx_data_a, b);
      end
      pop_one();
   endtask

   task automatic test_overflow();
      int o0;
      o0 = ovr_cnt;
      for (int i = 1; i <= 5; i++)
         send_rx(8'(i), 1'b1);
      vec_cnt++;
      if (ovr_cnt !== o0 + 1 || ovr_long !== 0) begin
         err_cnt++;
         $display("FAIL ovr_pulse got %0d pulses (%0d wide) exp 1 (0 wide)", ovr_cnt - o0, ovr_long);
      end
      for (int i = 1; i <= 4; i++) begin
         vec_cnt++;
         if (rx_valid_a !== 1'b1 || rx_data_a !== 8'(i)) begin
            err_cnt++;
            $display("FAIL ovr_pop%0d got valid=%b data=%h exp 1 %h", i, rx_valid_a, rx_data_a, 8'(i));
         end
         pop_one();
      end
      pop_one();
      vec_cnt++;
      if (rx_valid_a !== 1'b0) begin
         err_cnt++;
         $display("FAIL ovr_empty got valid=%b exp 0", rx_valid_a);
      end
   endtask

   task automatic test_full_push_pop();
      int o0, n;
      logic [7:0] b;
      exp_q.delete();
      for (int i = 0; i < DEPTH; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_rx(b, 1'b1);
      end
      o0 = ovr_cnt;
      b = 8'($urandom);
      n = 0;
      fork
         send_rx(b, 1'b1);
         begin
            // Stop bit is sampled 16 bit-ticks after the receiver enters STOP.
            while (rxs_a !== 2'd3 && n < 400) begin
               @(negedge clk);
               n++;
            end
            if (n < 400) begin
               repeat (15) @(negedge clk);
               rx_ready_a = 1'b1;
               @(negedge clk);
               rx_ready_a = 1'b0;
            end
         end
      join
      vec_cnt++;
      if (n >= 400) begin
         err_cnt++;
         $display("FAIL full_pp_timeout got %0d cycles exp <400", n);
      end
      void'(exp_q.pop_front());
      exp_q.push_back(b);
      vec_cnt++;
      if (ovr_cnt !== o0) begin
         err_cnt++;
         $display("FAIL full_pp_ovr got %0d pulses exp 0", ovr_cnt - o0);
      end
      while (exp_q.size() > 0) begin
         vec_cnt++;
         if (rx_valid_a !== 1'b1 || rx_data_a !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL full_pp_drain got valid=%b data=%h exp 1 %h", rx_valid_a, rx_data_a, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_one();
      end
   endtask

   task automatic test_rx_random();
      int f0, o0, ef, eo, npop;
      logic [7:0] b;
      logic stop_bit;
      exp_q.delete();
      ef = 0;
      eo = 0;
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      for (int t = 0; t < 14; t++) begin
         b = 8'($urandom);
         stop_bit = ($urandom_range(0, 5) != 0);
         send_rx(b, stop_bit);
         if (!stop_bit) ef++;
         else if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else eo++;
         vec_cnt++;
         if (ferr_cnt - f0 !== ef || ovr_cnt - o0 !== eo || rx_valid_a !== (exp_q.size() != 0)) begin
            err_cnt++;
            $display("FAIL rand_frame%0d got ferr=%0d ovr=%0d valid=%b exp %0d %0d %b", t,
                     ferr_cnt - f0, ovr_cnt - o0, rx_valid_a, ef, eo, exp_q.size() != 0);
         end
         npop = $urandom_range(0, 2);
         for (int p = 0; p < npop; p++) begin
            if (exp_q.size() > 0) begin
               vec_cnt++;
               if (rx_data_a !== exp_q[0]) begin
                  err_cnt++;
                  $display("FAIL rand_pop got %h exp %h", rx_data_a, exp_q[0]);
               end
               void'(exp_q.pop_front());
            end
            pop_one();
         end
      end
      while (exp_q.size() > 0) begin
         vec_cnt++;
         if (rx_valid_a !== 1'b1 || rx_data_a !== exp_q[0]) begin
            err_cnt++;
            $display("FAIL rand_drain got valid=%b data=%h exp 1 %h", rx_valid_a, rx_data_a, exp_q[0]);
         end
         void'(exp_q.pop_front());
         pop_one();
      end
   endtask

   task automatic test_tx_frame(input logic [7:0] b, input logic noisy);
      logic [9:0] fr;
      logic bad, got;
      fr = {1'b1, b, 1'b0};
      vec_cnt++;
      if (tx_ready_b !== 1'b1) begin
         err_cnt++;
         $display("FAIL tx_ready_pre got %b exp 1", tx_ready_b);
      end
      tx_data_b  = b;
      tx_valid_b = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         bad = 1'b0;
         got = fr[i];
         for (int c = 0; c < BIT_B; c++) begin
            if (txd_b !== fr[i] || tx_ready_b !== 1'b0) begin
               bad = 1'b1;
               got = txd_b;
            end
            tx_valid_b = (noisy && i < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noisy) tx_data_b = 8'($urandom);
            @(negedge clk);
         end
         vec_cnt++;
         if (bad) begin
            err_cnt++;
            $display("FAIL tx_bit%0d byte %h got txd=%b exp txd=%b with tx_ready=0", i, b, got, fr[i]);
         end
      end
      vec_cnt++;
      if (tx_ready_b !== 1'b1 || txd_b !== 1'b1) begin
         err_cnt++;
         $display("FAIL tx_done got ready=%b txd=%b exp 1 1 at 320 cycles", tx_ready_b, txd_b);
      end
   endtask

   task automatic test_tx();
      test_tx_frame(8'h3C, 1'b0);
      for (int i = 0; i < 3; i++)
         test_tx_frame(8'($urandom), 1'b1);
   endtask

   task automatic test_reset_mid_frame();
      int f0, o0;
      logic [7:0] b;
      logic [9:0] fr, cap;
      logic rdy_early;
      send_rx(8'($urandom), 1'b1);
      b  = 8'($urandom);
      fr = {1'b1, b, 1'b0};
      tx_data_a  = b;
      tx_valid_a = 1'b1;
      for (int k = 0; k < 5 * BIT_A + 8; k++) begin
         rxd_a = fr[k / BIT_A];
         @(negedge clk);
         tx_valid_a = 1'b0;
      end
      f0 = ferr_cnt;
      o0 = ovr_cnt;
      res   = 1'b1;
      rxd_a = 1'b1;
      @(negedge clk);
      res = 1'b0;
      vec_cnt++;
      if ({txd_a, tx_ready_a, rx_valid_a, rxs_a, txs_a} !== 7'b1100000) begin
         err_cnt++;
         $display("FAIL midreset got %b exp 1100000", {txd_a, tx_ready_a, rx_valid_a, rxs_a, txs_a});
      end
      repeat (40) @(negedge clk);
      vec_cnt++;
      if (rx_valid_a !== 1'b0 || ferr_cnt !== f0 || ovr_cnt !== o0) begin
         err_cnt++;
         $display("FAIL midreset_quiet got valid=%b ferr=%0d ovr=%0d exp 0 0 0", rx_valid_a, ferr_cnt - f0, ovr_cnt - o0);
      end
      send_rx(8'h12, 1'b1);
      vec_cnt++;
      if (rx_valid_a !== 1'b1 || rx_data_a !== 8'h12) begin
         err_cnt++;
         $display("FAIL midreset_rx got valid=%b data=%h exp 1 12", rx_valid_a, rx_data_a);
      end
      pop_one();
      tx_data_a  = 8'h12;
      tx_valid_a = 1'b1;
      @(negedge clk);
      tx_valid_a = 1'b0;
      repeat (BIT_A / 2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         cap[i] = txd_a;
         if (i < 9) repeat (BIT_A) @(negedge clk);
      end
      repeat (BIT_A / 2 - 1) @(negedge clk);
      rdy_early = tx_ready_a;
      @(negedge clk);
      vec_cnt++;
      if (cap !== {1'b1, 8'h12, 1'b0}) begin
         err_cnt++;
         $display("FAIL midreset_tx got %b exp %b", cap, {1'b1, 8'h12, 1'b0});
      end
      vec_cnt++;
      if (rdy_early !== 1'b0 || tx_ready_a !== 1'b1) begin
         err_cnt++;
         $display("FAIL midreset_tx_ready got %b%b exp 01 at cycles 159/160", rdy_early, tx_ready_a);
      end
   endtask

   initial begin
      res = 1'b1;
      rxd_a = 1'b1; rx_ready_a = 1'b0; tx_data_a = 8'd0; tx_valid_a = 1'b0;
      rxd_b = 1'b1; rx_ready_b = 1'b0; tx_data_b = 8'd0; tx_valid_b = 1'b0;
      @(negedge clk);
      test_reset();
      test_rx_basic();
      test_glitch();
      test_ferr();
      test_overflow();
      test_full_push_pop();
      test_rx_random();
      test_tx();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
